// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared types and constants for the prime range scanner
//
// Contents:
//   DEFAULT_WIDTH  default operand width
//   FIRST_DIVISOR  first trial divisor applied to every candidate
//   state_t        controller state encoding
package prime_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int FIRST_DIVISOR = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_TEST,
      ST_EMIT,
      ST_NEXT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/prime_scan_ctrl_if.sv
// rtl/prime_scan_ctrl_if.sv - command, status and result stream bundle of the prime scanner
//
// Signals:
//   start, range_lo, range_hi  scan request (master -> slave)
//   busy, done, prime_count    scan status (slave -> master)
//   out_valid, out_number      prime result stream (slave -> master)
//   out_ready                  result back-pressure (master -> slave)
// Modports: master = requester/consumer, slave = scan controller.
interface prime_scan_ctrl_if #(
   parameter int WIDTH = prime_pkg::DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] range_lo;
   logic [WIDTH-1:0] range_hi;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_number;
   logic             done;
   logic [WIDTH-1:0] prime_count;

   modport master (
      output start, range_lo, range_hi, out_ready,
      input  busy, out_valid, out_number, done, prime_count
   );

   modport slave (
      input  start, range_lo, range_hi, out_ready,
      output busy, out_valid, out_number, done, prime_count
   );

endinterface

// File: rtl/prime_trial_step.sv
// rtl/prime_trial_step.sv - one trial-division step on candidate n with divisor d
//
// Ports:
//   n_i             candidate (WIDTH bits)
//   d_i             current divisor (WIDTH+1 bits, always >= 2)
//   is_composite_o  n < 2, or d divides n before d*d exceeds n
//   is_prime_o      n >= 2 and d*d > n (no smaller divisor was found)
// Neither output set means: try the next divisor.
module prime_trial_step #(
   parameter int WIDTH = prime_pkg::DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] n_i,
   input  logic [WIDTH:0]   d_i,
   output logic             is_composite_o,
   output logic             is_prime_o
);

   logic [2*WIDTH-1:0] d_ext;
   logic [2*WIDTH-1:0] d_sq;
   logic [2*WIDTH-1:0] n_ext;
   logic [WIDTH:0]     rem;
   logic               below_two;
   logic               sq_exceeds;

   // Square at double width so a large divisor can never wrap into a false "d*d <= n".
   assign d_ext      = {{(WIDTH-1){1'b0}}, d_i};
   assign d_sq       = d_ext * d_ext;
   assign n_ext      = {{WIDTH{1'b0}}, n_i};
   assign rem        = {1'b0, n_i} % d_i;
   assign below_two  = (n_i < WIDTH'(2));
   assign sq_exceeds = (d_sq > n_ext);

   // Priority: n < 2, then d*d > n, then divisibility.
   assign is_composite_o = below_two || (!sq_exceeds && (rem == '0));
   assign is_prime_o     = !below_two && sq_exceeds;

endmodule

// File: rtl/prime_scan_ctrl.sv
// rtl/prime_scan_ctrl.sv - sweeps [range_lo, range_hi] and streams every prime found
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset
//   bus     prime_scan_ctrl_if.slave: start/range_lo/range_hi request, busy/done
//           status, out_valid/out_ready/out_number result stream, prime_count
// Build option: PRIME_SCAN_COUNT_EN builds a saturating prime counter behind
// prime_count; without it prime_count is tied to zero.
module prime_scan_ctrl
   import prime_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic              clock,
   input  logic              reset,
   prime_scan_ctrl_if.slave  bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH:0]   d_q, d_d;
   logic             is_composite;
   logic             is_prime;

`ifdef PRIME_SCAN_COUNT_EN
   logic [WIDTH-1:0] count_q, count_d;
`endif

   prime_trial_step #(.WIDTH(WIDTH)) u_step (
      .n_i            (n_q),
      .d_i            (d_q),
      .is_composite_o (is_composite),
      .is_prime_o     (is_prime)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         n_q     <= '0;
         d_q     <= (WIDTH+1)'(FIRST_DIVISOR);
`ifdef PRIME_SCAN_COUNT_EN
         count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         n_q     <= n_d;
         d_q     <= d_d;
`ifdef PRIME_SCAN_COUNT_EN
         count_q <= count_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      n_d     = n_q;
      d_d     = d_q;
`ifdef PRIME_SCAN_COUNT_EN
      count_d = count_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               lo_d    = bus.range_lo;
               hi_d    = bus.range_hi;
`ifdef PRIME_SCAN_COUNT_EN
               count_d = '0;
`endif
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (lo_q > hi_q) begin
               state_d = ST_DONE;
            end else begin
               n_d     = lo_q;
               d_d     = (WIDTH+1)'(FIRST_DIVISOR);
               state_d = ST_TEST;
            end
         end
         ST_TEST: begin
            if (is_composite) begin
               state_d = ST_NEXT;
            end else if (is_prime) begin
               state_d = ST_EMIT;
            end else begin
               d_d = d_q + (WIDTH+1)'(1);
            end
         end
         ST_EMIT: begin
            if (bus.out_ready) begin
`ifdef PRIME_SCAN_COUNT_EN
               if (count_q != '1) begin
                  count_d = count_q + WIDTH'(1);
               end
`endif
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            // Compare before incrementing so hi = all-ones ends the scan instead of wrapping.
            if (n_q == hi_q) begin
               state_d = ST_DONE;
            end else begin
               n_d     = n_q + WIDTH'(1);
               d_d     = (WIDTH+1)'(FIRST_DIVISOR);
               state_d = ST_TEST;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All outputs decode from registered state only; out_valid never looks at out_ready.
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.out_valid  = (state_q == ST_EMIT);
   assign bus.out_number = (state_q == ST_EMIT) ? n_q : '0;
   assign bus.done       = (state_q == ST_DONE);

`ifdef PRIME_SCAN_COUNT_EN
   assign bus.prime_count = count_q;
`else
   assign bus.prime_count = '0;
`endif

endmodule
